// File: rtl/cam_capture_ctrl_if.sv
// Wishbone register-bus bundle for the camera capture controller.
// Signal names keep the slave-side i_/o_ direction prefixes.
interface cam_capture_ctrl_if;
    logic [7:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb,
        output o_wb_rdt, o_wb_ack
    );

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb,
        input  o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Camera capture controller: decimates reader pixels into a frame buffer,
// with a Wishbone register block for control, status and buffer readback.
module cam_capture_ctrl #(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned PIX_W  = 12,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              i_wb_clk,
    input  logic              i_wb_rst,
    input  logic              i_pix_valid,
    input  logic [9:0]        i_pix_x,
    input  logic [8:0]        i_pix_y,
    input  logic [PIX_W-1:0]  i_pix_data,
    input  logic              i_frame_sof,
    input  logic              i_frame_eof,
    output logic              o_fb_we,
    output logic [ADDR_W-1:0] o_fb_waddr,
    output logic [PIX_W-1:0]  o_fb_wdata,
    output logic [ADDR_W-1:0] o_fb_raddr,
    input  logic [PIX_W-1:0]  i_fb_rdata,
    output logic              o_rec,
    output logic              o_irq,
    cam_capture_ctrl_if.slave wb
);

    localparam int unsigned CNT_W  = 2;
    localparam int unsigned FCNT_W = 16;
    localparam logic [2:0]  REG_CTRL   = 3'd0;
    localparam logic [2:0]  REG_STATUS = 3'd1;
    localparam logic [2:0]  REG_RADDR  = 3'd2;
    localparam logic [2:0]  REG_RDATA  = 3'd3;
    localparam logic [2:0]  REG_FCNT   = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          dec_q, dec_d;
    logic [1:0]          dec_cfg_q, dec_cfg_d;
    logic                cont_q, cont_d;
    logic                irq_en_q, irq_en_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic                ovr_q, ovr_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [PIX_W-1:0]    wdata_q, wdata_d;
    logic                rec_q, rec_d;
    logic                irq_q, irq_d;
    logic                ack_q, ack_d;
    logic [31:0]         rdt_q, rdt_d;
    logic                served_q, served_d;
    logic                rd_pend_q, rd_pend_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;

    logic                req_c;
    logic                accept_c;
    logic [2:0]          sel_c;
    logic                done_w1c_c;
    logic                ovr_w1c_c;
    logic                busy_c;
    logic [1:0]          dec_eff_c;
    logic [9:0]          pix_mask_c;
    logic                pix_hit_c;
    logic [9:0]          x_s_c;
    logic [8:0]          y_s_c;
    logic [31:0]         h_s_c;
    logic [31:0]         lin_addr_c;
    logic                unused_ok;

    assign unused_ok  = ^{wb.i_wb_adr[7:5], wb.i_wb_adr[1:0], wb.i_wb_dat[31:ADDR_W]};
    assign busy_c     = (state_q != IDLE);
    assign dec_eff_c  = (dec_cfg_q == 2'd3) ? 2'd2 : dec_cfg_q;
    assign req_c      = wb.i_wb_cyc & wb.i_wb_stb;
    assign accept_c   = req_c & ~served_q & ~ack_q & ~rd_pend_q;
    assign sel_c      = wb.i_wb_adr[4:2];

    // Pixel qualification and decimated linear address
    assign pix_mask_c = 10'((10'd1 << dec_q) - 10'd1);
    assign pix_hit_c  = i_pix_valid
                      && (32'(i_pix_x) < H_RES) && (32'(i_pix_y) < V_RES)
                      && ((i_pix_x & pix_mask_c) == 10'd0)
                      && ((i_pix_y & pix_mask_c[8:0]) == 9'd0);
    assign x_s_c      = i_pix_x >> dec_q;
    assign y_s_c      = i_pix_y >> dec_q;
    assign h_s_c      = 32'(H_RES >> dec_q);
    assign lin_addr_c = 32'(32'(y_s_c) * h_s_c) + 32'(x_s_c);

    // Wishbone register access; one ack per cyc&stb assertion
    always_comb begin
        ack_d      = 1'b0;
        rdt_d      = rdt_q;
        start_d    = 1'b0;
        cont_d     = cont_q;
        dec_cfg_d  = dec_cfg_q;
        irq_en_d   = irq_en_q;
        raddr_d    = raddr_q;
        done_w1c_c = 1'b0;
        ovr_w1c_c  = 1'b0;
        rd_pend_d  = rd_pend_q;
        rd_cnt_d   = rd_cnt_q;
        served_d   = req_c ? served_q : 1'b0;

        if (accept_c) begin
            served_d = 1'b1;
            if (wb.i_wb_we) begin
                ack_d = 1'b1;
                rdt_d = 32'd0;
                unique case (sel_c)
                    REG_CTRL: begin
                        start_d   = wb.i_wb_dat[0];
                        cont_d    = wb.i_wb_dat[1];
                        dec_cfg_d = wb.i_wb_dat[3:2];
                        irq_en_d  = wb.i_wb_dat[4];
                    end
                    REG_STATUS: begin
                        done_w1c_c = wb.i_wb_dat[1];
                        ovr_w1c_c  = wb.i_wb_dat[2];
                    end
                    REG_RADDR: raddr_d = wb.i_wb_dat[ADDR_W-1:0];
                    default: ;
                endcase
            end else if (sel_c == REG_RDATA) begin
                rd_pend_d = 1'b1;
                rd_cnt_d  = CNT_W'(RD_LAT);
            end else begin
                ack_d = 1'b1;
                unique case (sel_c)
                    REG_CTRL:   rdt_d = {27'd0, irq_en_q, dec_cfg_q, cont_q, 1'b0};
                    REG_STATUS: rdt_d = {29'd0, ovr_q, done_q, busy_c};
                    REG_RADDR:  rdt_d = 32'(raddr_q);
                    REG_FCNT:   rdt_d = 32'(fcnt_q);
                    default:    rdt_d = 32'd0;
                endcase
            end
        end else if (rd_pend_q) begin
            if (rd_cnt_q == CNT_W'(1)) begin
                rd_pend_d = 1'b0;
                ack_d     = 1'b1;
                rdt_d     = 32'(i_fb_rdata);
            end else begin
                rd_cnt_d = rd_cnt_q - CNT_W'(1);
            end
        end
    end

    // Capture FSM: next state, pixel writes, status and frame counter
    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = done_q & ~done_w1c_c;
        ovr_d   = ovr_q & ~ovr_w1c_c;
        fcnt_d  = fcnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_q) begin
                    state_d = ARM;
                    dec_d   = dec_eff_c;
                end
            end
            ARM: begin
                if (i_frame_sof) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (pix_hit_c) begin
                    we_d    = 1'b1;
                    waddr_d = ADDR_W'(lin_addr_c);
                    wdata_d = i_pix_data;
                end
                // eof wins over a coincident sof: the frame in flight completes
                if (i_frame_eof) begin
                    done_d = 1'b1;
                    fcnt_d = fcnt_q + FCNT_W'(1);
                    if (cont_q) begin
                        state_d = ARM;
                        dec_d   = dec_eff_c;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (i_frame_sof) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        rec_d = (state_d != IDLE);
        irq_d = done_d & irq_en_d;
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q   <= IDLE;
            dec_q     <= 2'd0;
            dec_cfg_q <= 2'd0;
            cont_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            raddr_q   <= '0;
            fcnt_q    <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            rec_q     <= 1'b0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdt_q     <= 32'd0;
            served_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            dec_cfg_q <= dec_cfg_d;
            cont_q    <= cont_d;
            irq_en_q  <= irq_en_d;
            start_q   <= start_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            raddr_q   <= raddr_d;
            fcnt_q    <= fcnt_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            rec_q     <= rec_d;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
            rdt_q     <= rdt_d;
            served_q  <= served_d;
            rd_pend_q <= rd_pend_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    assign o_fb_we     = we_q;
    assign o_fb_waddr  = waddr_q;
    assign o_fb_wdata  = wdata_q;
    assign o_fb_raddr  = raddr_q;
    assign o_rec       = rec_q;
    assign o_irq       = irq_q;
    assign wb.o_wb_ack = ack_q;
    assign wb.o_wb_rdt = rdt_q;

endmodule
